aes_inv_round_ctrl: RTL

- Iterative AES inverse-cipher round sequencer.
- Owns the 128-bit state register and one combinational round datapath: inverse ShiftRows, inverse SubBytes, AddRoundKey, inverse MixColumns.
- Fetches round keys from the key-expansion store through an address port, in decreasing order from NR down to 0.
- Sits between the ciphertext source and the plaintext consumer, with valid/ready handshakes on both sides.

---
 rtl/aes_inv_round_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher: one round per clock on a 128-bit state register,
// with round keys fetched in descending order from an asynchronous-read key store.
module aes_inv_round_ctrl #(
    parameter int NR  = 10,
    parameter int KAW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [KAW-1:0] key_addr,
    input  logic [127:0]   key_data,
    output logic           key_lock,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic [KAW-1:0] round_cnt
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
    end

    localparam logic [KAW-1:0] NR_K   = KAW'(NR);
    localparam logic [KAW-1:0] NRM1_K = KAW'(NR - 1);
    localparam logic [KAW-1:0] ONE_K  = KAW'(1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t           fsm, fsm_nxt;
    logic [127:0]   state, state_nxt, rnd_sub, rnd_mix;
    logic [KAW-1:0] key_addr_nxt, round_cnt_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] p, r;
        p = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2[i]  = xtime(a[i]);
            x4[i]  = xtime(x2[i]);
            x8[i]  = xtime(x4[i]);
            m9[i]  = x8[i] ^ a[i];
            m11[i] = x8[i] ^ x2[i] ^ a[i];
            m13[i] = x8[i] ^ x4[i] ^ a[i];
            m14[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    always_comb begin
        rnd_sub       = inv_sub_bytes(inv_shift_rows(state)) ^ key_data;
        rnd_mix       = inv_mix_columns(rnd_sub);
        fsm_nxt       = fsm;
        state_nxt     = state;
        key_addr_nxt  = key_addr;
        round_cnt_nxt = round_cnt;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    state_nxt     = in_data ^ key_data;
                    key_addr_nxt  = NRM1_K;
                    round_cnt_nxt = NRM1_K;
                    fsm_nxt       = ROUND;
                end
            end
            ROUND: begin
                state_nxt = rnd_mix;
                if (round_cnt == ONE_K) begin
                    key_addr_nxt  = '0;
                    round_cnt_nxt = '0;
                    fsm_nxt       = FINAL;
                end else begin
                    key_addr_nxt  = key_addr - ONE_K;
                    round_cnt_nxt = round_cnt - ONE_K;
                end
            end
            FINAL: begin
                state_nxt = rnd_sub;
                fsm_nxt   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    key_addr_nxt  = NR_K;
                    round_cnt_nxt = NR_K;
                    fsm_nxt       = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state     <= '0;
            key_addr  <= NR_K;
            round_cnt <= NR_K;
        end else begin
            fsm       <= fsm_nxt;
            state     <= state_nxt;
            key_addr  <= key_addr_nxt;
            round_cnt <= round_cnt_nxt;
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign key_lock  = (fsm != IDLE);
    assign out_data  = (fsm == DONE) ? state : '0;

endmodule
